// File: rtl/prio_encoder_q_pkg.sv
// Shared encoder definitions: FSM state type, width helper and a reusable
// wrap-around priority pick used by the registered priority encoders.
package enc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } enc_state_t;

  // Widest request vector the generic pick function can handle.
  localparam int PICK_MAX = 64;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } pick_t;

  // Index width that never collapses to zero for tiny vectors.
  function automatic int safe_clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Descending search of the low n bits of vec, starting at 'start' and
  // wrapping from 0 back to n-1. Returns the first set index and a found flag.
  function automatic pick_t prio_pick(input logic [63:0] vec,
                                      input logic [5:0]  start,
                                      input int          n);
    pick_t r;
    int    i;
    r = '0;
    for (int k = 0; k < PICK_MAX; k++) begin
      if (k < n && !r.found) begin
        i = int'(start) - k;
        if (i < 0) i = i + n;
        if (vec[i[5:0]]) begin
          r.found = 1'b1;
          r.idx   = i[5:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_encoder_q_pick.sv
// Combinational N-bit rotate-and-priority-encode: finds the first set bit of
// vec searching downward from start, wrapping past index 0 to N-1.
module prio_pick_comb
  import enc_pkg::*;
#(
  parameter int  N = 8,
  localparam int W = safe_clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  pick_t       res;
  logic [63:0] vec_ext;
  logic [5:0]  start_ext;
  logic        unused_bits;

  // Widen operands to the generic function's width and run the search.
  always_comb begin
    vec_ext            = '0;
    vec_ext[N-1:0]     = vec;
    start_ext          = '0;
    start_ext[W-1:0]   = start;
    res                = prio_pick(vec_ext, start_ext, N);
  end

  assign found       = res.found;
  assign idx         = res.idx[W-1:0];
  assign unused_bits = ^res.idx;

endmodule

// File: rtl/prio_encoder_q.sv
// Registered priority encoder with sticky pending bits, per-bit eligibility
// mask and a valid/ready grant output. Fixed priority (highest index wins)
// or round-robin selection.
module prio_encoder_q
  import enc_pkg::*;
#(
  parameter int  N  = 8,
  parameter int  RR = 0,
  localparam int W  = safe_clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  input  logic         out_ready,
  output logic [N-1:0] pending
);

  localparam logic [W-1:0] TOP_IDX = W'(N - 1);
  localparam logic [N-1:0] ONE_N   = N'(1);

  enc_state_t   state;
  logic [W-1:0] rr_ptr;
  logic         handshake;
  logic [N-1:0] clr;
  logic [N-1:0] pick_vec;
  logic [W-1:0] pick_start;
  logic [W-1:0] next_start;
  logic         pick_found;
  logic [W-1:0] pick_idx;

  assign out_valid = (state == ST_PRESENT);
  assign handshake = out_valid && out_ready;

  // Search start after accepting out_idx: one below it, wrapping to the top.
  // The picker sees the eligible set minus the bit being accepted, so a
  // back-to-back grant never repeats the index just handed out.
  always_comb begin
    clr        = '0;
    next_start = (out_idx == '0) ? TOP_IDX : out_idx - W'(1);
    if (handshake) clr = ONE_N << out_idx;
    pick_vec   = pending & mask & ~clr;
    pick_start = TOP_IDX;
    if (RR != 0) pick_start = handshake ? next_start : rr_ptr;
  end

  prio_pick_comb #(.N(N)) u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Pending capture, grant FSM and round-robin search start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      state   <= ST_IDLE;
      out_idx <= '0;
      rr_ptr  <= TOP_IDX;
    end else begin
      pending <= (pending & ~clr) | req;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            out_idx <= pick_idx;
            state   <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            if (RR != 0) rr_ptr <= next_start;
            if (pick_found) out_idx <= pick_idx;
            else            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Scoreboard bench: one fixed-priority and one round-robin instance share the
// same stimulus; a reference model pushes expected grants into queues and a
// monitor pops them on every handshake.
module tb_prio_encoder_q;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       out_ready;

  logic       fix_valid, rr_valid;
  logic [2:0] fix_idx, rr_idx;
  logic [7:0] fix_pend, rr_pend;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pend  [2];
  bit         m_valid [2];
  int         m_idx   [2];
  int         m_start [2];
  int         exp_q0[$];
  int         exp_q1[$];

  prio_encoder_q #(.N(8), .RR(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask),
    .out_valid(fix_valid), .out_idx(fix_idx), .out_ready(out_ready),
    .pending(fix_pend)
  );

  prio_encoder_q #(.N(8), .RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask),
    .out_valid(rr_valid), .out_idx(rr_idx), .out_ready(out_ready),
    .pending(rr_pend)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m,
                               input bit rdy, input int n);
    repeat (n) begin
      @(negedge clk);
      req       = r;
      mask      = m;
      out_ready = rdy;
    end
  endtask

  // Keep acknowledging with no new requests until both DUTs are empty.
  task automatic drain();
    int c;
    c = 0;
    while ((fix_valid || rr_valid || fix_pend != 0 || rr_pend != 0) && c < 40) begin
      applyStimulus(8'h00, 8'hFF, 1'b1, 1);
      c++;
    end
    applyStimulus(8'h00, 8'hFF, 1'b1, 2);
    checkOutput("drain_timeout", (c >= 40) ? 1 : 0, 0);
  endtask

  // First pending index found when scanning downward from 'start', wrapping.
  function automatic int ref_pick(input logic [7:0] v, input int start);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (start - k + 8) % 8;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic push_exp(input int m, input int v);
    if (m == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  // Reference model: pending set, current offer and next search start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m]  = 8'h00;
        m_valid[m] = 1'b0;
        m_idx[m]   = 0;
        m_start[m] = 7;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        logic [7:0] elig;
        logic [7:0] rem;
        logic [7:0] taken;
        bit         hs;
        int         old;
        elig  = m_pend[m] & mask;
        hs    = m_valid[m] && out_ready;
        old   = m_idx[m];
        taken = hs ? (8'h01 << old) : 8'h00;
        if (!m_valid[m]) begin
          if (elig != 0) begin
            m_idx[m]   = ref_pick(elig, m_start[m]);
            m_valid[m] = 1'b1;
            push_exp(m, m_idx[m]);
          end
        end else if (hs) begin
          m_start[m] = (m == 1) ? (old + 7) % 8 : 7;
          rem = elig & ~taken;
          if (rem != 0) begin
            m_idx[m] = ref_pick(rem, m_start[m]);
            push_exp(m, m_idx[m]);
          end else begin
            m_valid[m] = 1'b0;
          end
        end
        m_pend[m] = (m_pend[m] & ~taken) | req;
      end
    end
  end

  // Monitor: compare status every cycle and pop the scoreboard on handshakes.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        checkOutput("fix_valid", int'(fix_valid), int'(m_valid[0]));
        checkOutput("rr_valid",  int'(rr_valid),  int'(m_valid[1]));
        checkOutput("fix_pending", int'(fix_pend), int'(m_pend[0]));
        checkOutput("rr_pending",  int'(rr_pend),  int'(m_pend[1]));
        if (fix_valid && out_ready) begin
          checkOutput("fix_sb_nonempty", (exp_q0.size() > 0) ? 1 : 0, 1);
          if (exp_q0.size() > 0) checkOutput("fix_grant", int'(fix_idx), exp_q0.pop_front());
        end
        if (rr_valid && out_ready) begin
          checkOutput("rr_sb_nonempty", (exp_q1.size() > 0) ? 1 : 0, 1);
          if (exp_q1.size() > 0) checkOutput("rr_grant", int'(rr_idx), exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req       = 8'h00;
    mask      = 8'hFF;
    out_ready = 1'b0;
    #2;
    checkOutput("reset_fix_valid", int'(fix_valid), 0);
    checkOutput("reset_fix_idx", int'(fix_idx), 0);
    checkOutput("reset_rr_pending", int'(rr_pend), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Single pulse of three requests, consumer always ready.
    applyStimulus(8'hA2, 8'hFF, 1'b1, 1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 6);

    // Stall with a late higher-priority arrival.
    applyStimulus(8'h08, 8'hFF, 1'b0, 1);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1);
    applyStimulus(8'h80, 8'hFF, 1'b0, 1);
    applyStimulus(8'h00, 8'hFF, 1'b0, 2);
    applyStimulus(8'h00, 8'hFF, 1'b1, 5);

    // Held requests with continuous ready: rotation vs fixed priority.
    applyStimulus(8'h91, 8'hFF, 1'b1, 12);
    drain();

    // Masked bit stays pending until the mask opens.
    applyStimulus(8'h60, 8'h3F, 1'b1, 1);
    applyStimulus(8'h00, 8'h3F, 1'b1, 5);
    applyStimulus(8'h00, 8'hFF, 1'b1, 4);

    // Re-request of the index being accepted in the same cycle.
    applyStimulus(8'h04, 8'hFF, 1'b0, 1);
    applyStimulus(8'h00, 8'hFF, 1'b0, 2);
    applyStimulus(8'h04, 8'hFF, 1'b1, 1);
    applyStimulus(8'h00, 8'hFF, 1'b1, 5);

    // Everything masked: no grant, pending keeps accumulating.
    applyStimulus(8'hFF, 8'h00, 1'b1, 3);
    drain();

    // Asynchronous reset in the middle of a stalled burst.
    applyStimulus(8'hF0, 8'hFF, 1'b0, 3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_fix_valid", int'(fix_valid), 0);
    checkOutput("async_rst_rr_valid", int'(rr_valid), 0);
    checkOutput("async_rst_fix_pending", int'(fix_pend), 0);
    checkOutput("async_rst_rr_pending", int'(rr_pend), 0);
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h91, 8'hFF, 1'b1, 1);
    drain();

    // Randomised traffic with random masking and back-pressure.
    for (int c = 0; c < 400; c++) begin
      logic [7:0] r;
      logic [7:0] m;
      bit         rdy;
      r   = 8'($urandom & $urandom);
      m   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
      rdy = ($urandom_range(2) != 0);
      applyStimulus(r, m, rdy, 1);
    end
    drain();

    checkOutput("fix_sb_leftover", exp_q0.size(), 0);
    checkOutput("rr_sb_leftover", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
